// File: rtl/pe_pkg.sv
// Shared types and parameters for the PE reducer issue path (dispatcher side).
// Optional feature: PE_DISPATCH_ZERO_SKIP_EN drops entries with a zero operand.
package pe_pkg;
    localparam int LANES      = 3;
    localparam int DATA_W     = 16;
    localparam int AFIELD_W   = 7;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = $clog2(LANES + 1);

    typedef logic [2:0][AFIELD_W-1:0] addr_t;
    typedef logic signed [DATA_W-1:0] data_t;

    typedef struct packed {
        addr_t addr;
        data_t w;
        data_t ia;
        logic  last;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } disp_state_e;

    // An entry contributes nothing to the reduction when either operand is zero.
    function automatic logic is_zero_op(entry_t e);
        return (e.w == {DATA_W{1'b0}}) || (e.ia == {DATA_W{1'b0}});
    endfunction
endpackage

// File: rtl/pe_dispatcher_if.sv
// Operand stream in / issue group out bundle between fetch logic, dispatcher and PEReducer.
// slave: the dispatcher; master: whoever feeds entries and plays PEReducer.
interface pe_dispatcher_if;
    import pe_pkg::*;

    logic                   i_valid;
    logic                   o_ready;
    addr_t                  i_addr;
    data_t                  i_w;
    data_t                  i_ia;
    logic                   i_last;
    logic                   o_start;
    addr_t [LANES-1:0]      o_addr;
    data_t [LANES-1:0]      o_w;
    data_t [LANES-1:0]      o_ia;
    logic                   i_finish;
    logic                   o_tile_done;

    modport slave (
        input  i_valid, i_addr, i_w, i_ia, i_last, i_finish,
        output o_ready, o_start, o_addr, o_w, o_ia, o_tile_done
    );

    modport master (
        output i_valid, i_addr, i_w, i_ia, i_last, i_finish,
        input  o_ready, o_start, o_addr, o_w, o_ia, o_tile_done
    );
endinterface

// File: rtl/pe_disp_fifo.sv
// Synchronous FIFO of operand entries. o_ready is registered so it reads 0
// while reset is held and rises on the first clock after release.
module pe_disp_fifo
    import pe_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_push,
    input  entry_t i_data,
    input  logic   i_pop,
    output entry_t o_data,
    output logic   o_empty,
    output logic   o_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              ready_q, ready_d;
    logic              full_s, push_ok_s, pop_ok_s;

    assign full_s    = (count_q == FULL_CNT);
    assign o_empty   = (count_q == {(PTR_W + 1){1'b0}});
    assign push_ok_s = i_push && (!full_s || i_pop);
    assign pop_ok_s  = i_pop && !o_empty;
    assign o_data    = mem_q[rd_ptr_q];
    assign o_ready   = ready_q;

    // Next-state for storage, pointers, occupancy and the registered ready flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_CNT);
    end

    // FIFO state registers with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
            ready_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end
endmodule

// File: rtl/pe_dispatcher.sv
// Packs buffered (addr, w, ia) entries into LANES-wide groups and issues them
// to PEReducer with a start/finish handshake; i_last flushes and ends a tile.
// Optional build macro PE_DISPATCH_ZERO_SKIP_EN discards zero-operand entries.
module pe_dispatcher
    import pe_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    pe_dispatcher_if.slave   bus
);
    entry_t              push_data_s, pop_data_s;
    logic                fifo_empty_s, fifo_ready_s, pop_s, skip_s;

    disp_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tile_q, tile_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    addr_t [LANES-1:0]   lane_addr_q, lane_addr_d;
    data_t [LANES-1:0]   lane_w_q, lane_w_d;
    data_t [LANES-1:0]   lane_ia_q, lane_ia_d;
    logic                do_pad_s;
    logic [CNT_W-1:0]    pad_from_s;
    logic [CNT_W-1:0]    fill_cnt_s;

    // Pack the incoming bus fields into a FIFO entry.
    always_comb begin
        push_data_s.addr = bus.i_addr;
        push_data_s.w    = bus.i_w;
        push_data_s.ia   = bus.i_ia;
        push_data_s.last = bus.i_last;
    end

    pe_disp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (bus.i_valid & fifo_ready_s),
        .i_data  (push_data_s),
        .i_pop   (pop_s),
        .o_data  (pop_data_s),
        .o_empty (fifo_empty_s),
        .o_ready (fifo_ready_s)
    );

    assign pop_s      = (state_q == S_FILL) && !fifo_empty_s;
    assign fill_cnt_s = cnt_q + CNT_W'(1);

`ifdef PE_DISPATCH_ZERO_SKIP_EN
    assign skip_s = is_zero_op(pop_data_s);
`else
    assign skip_s = 1'b0;
`endif

    assign bus.o_ready     = fifo_ready_s;
    assign bus.o_start     = start_q;
    assign bus.o_tile_done = done_q;
    assign bus.o_addr      = lane_addr_q;
    assign bus.o_w         = lane_w_q;
    assign bus.o_ia        = lane_ia_q;

    // Group-building FSM: fill lanes, pulse start, hold for finish, close the tile.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_d      = tile_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        lane_addr_d = lane_addr_q;
        lane_w_d    = lane_w_q;
        lane_ia_d   = lane_ia_q;
        do_pad_s    = 1'b0;
        pad_from_s  = cnt_q;
        case (state_q)
            S_FILL: begin
                if (pop_s) begin
                    if (skip_s) begin
                        if (pop_data_s.last) begin
                            tile_d = 1'b1;
                            if (cnt_q != {CNT_W{1'b0}}) begin
                                do_pad_s   = 1'b1;
                                pad_from_s = cnt_q;
                                start_d    = 1'b1;
                                state_d    = S_ISSUE;
                            end else begin
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        lane_addr_d[cnt_q] = pop_data_s.addr;
                        lane_w_d[cnt_q]    = pop_data_s.w;
                        lane_ia_d[cnt_q]   = pop_data_s.ia;
                        cnt_d              = fill_cnt_s;
                        if ((fill_cnt_s == CNT_W'(LANES)) || pop_data_s.last) begin
                            tile_d     = tile_q | pop_data_s.last;
                            do_pad_s   = 1'b1;
                            pad_from_s = fill_cnt_s;
                            start_d    = 1'b1;
                            state_d    = S_ISSUE;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_finish) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (tile_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                tile_d  = 1'b0;
                state_d = S_FILL;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        // Unfilled lanes repeat lane 0's address with zero operands so they add nothing.
        if (do_pad_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (CNT_W'(i) >= pad_from_s) begin
                    lane_addr_d[i] = lane_addr_d[0];
                    lane_w_d[i]    = {DATA_W{1'b0}};
                    lane_ia_d[i]   = {DATA_W{1'b0}};
                end else begin
                    lane_addr_d[i] = lane_addr_d[i];
                end
            end
        end else begin
            pad_from_s = pad_from_s;
        end
    end

    // FSM, lane and output registers with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_FILL;
            cnt_q       <= {CNT_W{1'b0}};
            tile_q      <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            lane_addr_q <= {(LANES * 3 * AFIELD_W){1'b0}};
            lane_w_q    <= {(LANES * DATA_W){1'b0}};
            lane_ia_q   <= {(LANES * DATA_W){1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_q      <= tile_d;
            start_q     <= start_d;
            done_q      <= done_d;
            lane_addr_q <= lane_addr_d;
            lane_w_q    <= lane_w_d;
            lane_ia_q   <= lane_ia_d;
        end
    end
endmodule

// File: tb/tb_pe_dispatcher.sv
// Directed bench for pe_dispatcher; the zero-skip scenario follows PE_DISPATCH_ZERO_SKIP_EN.
module tb_pe_dispatcher;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fin_man = 1'b0;
    logic fin_auto = 1'b0;
    logic auto_en = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    int   start_cnt = 0;
    int   tile_cnt = 0;

    addr_t [LANES-1:0] cap_addr [64];
    data_t [LANES-1:0] cap_w    [64];
    data_t [LANES-1:0] cap_ia   [64];

    pe_dispatcher_if bus_if ();

    pe_dispatcher dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    assign bus_if.i_finish = fin_man | fin_auto;

    // Record every issued group and count tile completions; optionally answer finish.
    always @(posedge clk) begin
        if (bus_if.o_start) begin
            cap_addr[start_cnt[5:0]] <= bus_if.o_addr;
            cap_w[start_cnt[5:0]]    <= bus_if.o_w;
            cap_ia[start_cnt[5:0]]   <= bus_if.o_ia;
            start_cnt <= start_cnt + 1;
        end
        if (bus_if.o_tile_done) tile_cnt <= tile_cnt + 1;
        fin_auto <= auto_en & bus_if.o_start;
    end

    function automatic addr_t mk_addr(int k);
        addr_t a;
        a[0] = 7'(k);
        a[1] = 7'(k + 1);
        a[2] = 7'(k + 2);
        return a;
    endfunction

    function automatic logic [52:0] lane_val(int k, int w, int ia);
        return {mk_addr(k), 16'(w), 16'(ia)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lane(string tag, int g, int l, logic [52:0] exp);
        check(tag, 64'({cap_addr[g][l], cap_w[g][l], cap_ia[g][l]}), 64'(exp));
    endtask

    task automatic push(int k, int w, int ia, logic last);
        logic acc;
        acc = 1'b0;
        bus_if.i_valid = 1'b1;
        bus_if.i_addr  = mk_addr(k);
        bus_if.i_w     = 16'(w);
        bus_if.i_ia    = 16'(ia);
        bus_if.i_last  = last;
        for (int i = 0; i < 60; i++) begin
            acc = bus_if.o_ready;
            tick();
            if (acc) break;
        end
        bus_if.i_valid = 1'b0;
        bus_if.i_last  = 1'b0;
        check("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_starts(int n, string tag);
        for (int i = 0; i < 100 && start_cnt < n; i++) tick();
        check(tag, 64'(start_cnt >= n), 64'd1);
    endtask

    task automatic wait_tiles(int n, string tag);
        for (int i = 0; i < 150 && tile_cnt < n; i++) tick();
        check(tag, 64'(tile_cnt >= n), 64'd1);
    endtask

    initial begin
        logic [158:0] snap;
        int k, acc, s0, t0, idx;
        logic a;
        bus_if.i_valid = 1'b0;
        bus_if.i_addr  = '0;
        bus_if.i_w     = 16'sd0;
        bus_if.i_ia    = 16'sd0;
        bus_if.i_last  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", 64'(bus_if.o_ready), 64'd0);
        check("rst_start", 64'(bus_if.o_start), 64'd0);
        check("rst_done", 64'(bus_if.o_tile_done), 64'd0);
        check("rst_w", 64'(bus_if.o_w), 64'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(bus_if.o_ready), 64'd1);

        // 1: single full tile
        push(0, 15, 3, 1'b0);
        push(1, 16, 2, 1'b0);
        push(2, 17, 1, 1'b1);
        wait_starts(1, "t1_start");
        check("t1_start_pulse", 64'(bus_if.o_start), 64'd0);
        chk_lane("t1_lane0", 0, 0, lane_val(0, 15, 3));
        chk_lane("t1_lane1", 0, 1, lane_val(1, 16, 2));
        chk_lane("t1_lane2", 0, 2, lane_val(2, 17, 1));
        tick();
        tick();
        fin_man = 1'b1;
        tick();
        fin_man = 1'b0;
        check("t1_tile_done", 64'(bus_if.o_tile_done), 64'd1);
        tick();
        check("t1_tile_done_pulse", 64'(bus_if.o_tile_done), 64'd0);
        check("t1_tile_cnt", 64'(tile_cnt), 64'd1);

        // 2: five entries, partial second group
        auto_en = 1'b1;
        for (int i = 10; i <= 14; i++) push(i, 100 + i, 200 + i, 1'(i == 14));
        wait_tiles(2, "t2_tile");
        repeat (4) tick();
        check("t2_starts", 64'(start_cnt), 64'd3);
        check("t2_tiles", 64'(tile_cnt), 64'd2);
        for (int l = 0; l < 3; l++) chk_lane("t2_g1", 1, l, lane_val(10 + l, 110 + l, 210 + l));
        chk_lane("t2_g2_l0", 2, 0, lane_val(13, 113, 213));
        chk_lane("t2_g2_l1", 2, 1, lane_val(14, 114, 214));
        chk_lane("t2_g2_pad", 2, 2, {mk_addr(13), 32'd0});

        // 3: back-pressure while PEReducer stalls
        auto_en = 1'b0;
        for (int i = 20; i <= 22; i++) push(i, 100 + i, 200 + i, 1'b0);
        wait_starts(4, "t3_start");
        snap = {bus_if.o_addr, bus_if.o_w, bus_if.o_ia};
        k = 23;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            bus_if.i_valid = 1'b1;
            bus_if.i_addr  = mk_addr(k);
            bus_if.i_w     = 16'(100 + k);
            bus_if.i_ia    = 16'(200 + k);
            bus_if.i_last  = 1'(k == 32);
            a = bus_if.o_ready;
            tick();
            if (a) begin
                acc++;
                k++;
            end
            check("t3_stable", 64'(snap === {bus_if.o_addr, bus_if.o_w, bus_if.o_ia}), 64'd1);
        end
        bus_if.i_valid = 1'b0;
        bus_if.i_last  = 1'b0;
        check("t3_accepts", 64'(acc), 64'd8);
        check("t3_ready_low", 64'(bus_if.o_ready), 64'd0);
        check("t3_no_issue", 64'(start_cnt), 64'd4);
        fin_man = 1'b1;
        tick();
        fin_man = 1'b0;
        auto_en = 1'b1;
        while (k <= 32) begin
            push(k, 100 + k, 200 + k, 1'(k == 32));
            k++;
        end
        wait_tiles(3, "t3_tile");
        repeat (4) tick();
        check("t3_starts", 64'(start_cnt), 64'd8);
        for (int g = 0; g < 5; g++) begin
            for (int l = 0; l < 3; l++) begin
                idx = 20 + 3 * g + l;
                if (idx <= 32) chk_lane("t3_lane", 3 + g, l, lane_val(idx, 100 + idx, 200 + idx));
                else           chk_lane("t3_pad", 3 + g, l, {mk_addr(32), 32'd0});
            end
        end

        // 4: reset in the middle of WAIT
        auto_en = 1'b0;
        for (int i = 40; i <= 42; i++) push(i, 100 + i, 200 + i, 1'b0);
        wait_starts(9, "t4_start");
        rst = 1'b1;
        tick();
        check("t4_rst_start", 64'(bus_if.o_start), 64'd0);
        check("t4_rst_done", 64'(bus_if.o_tile_done), 64'd0);
        check("t4_rst_lanes", 64'({bus_if.o_addr, bus_if.o_w, bus_if.o_ia} == 159'd0), 64'd1);
        check("t4_rst_ready", 64'(bus_if.o_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("t4_ready", 64'(bus_if.o_ready), 64'd1);
        auto_en = 1'b1;
        push(43, 143, 243, 1'b0);
        push(44, 144, 244, 1'b0);
        push(45, 145, 245, 1'b1);
        wait_tiles(4, "t4_tile");
        repeat (4) tick();
        check("t4_starts", 64'(start_cnt), 64'd10);
        check("t4_tiles", 64'(tile_cnt), 64'd4);
        for (int l = 0; l < 3; l++) chk_lane("t4_lane", 9, l, lane_val(43 + l, 143 + l, 243 + l));

        // 5: zero operands
        push(50, 0, 7, 1'b0);
        push(51, 4, 3, 1'b0);
        push(52, 9, 0, 1'b1);
        wait_tiles(5, "t5_tile");
        repeat (3) tick();
        check("t5_starts", 64'(start_cnt), 64'd11);
`ifdef PE_DISPATCH_ZERO_SKIP_EN
        chk_lane("t5_l0", 10, 0, lane_val(51, 4, 3));
        chk_lane("t5_pad1", 10, 1, {mk_addr(51), 32'd0});
        chk_lane("t5_pad2", 10, 2, {mk_addr(51), 32'd0});
`else
        chk_lane("t5_l0", 10, 0, lane_val(50, 0, 7));
        chk_lane("t5_l1", 10, 1, lane_val(51, 4, 3));
        chk_lane("t5_l2", 10, 2, lane_val(52, 9, 0));
`endif
        push(53, 0, 5, 1'b0);
        push(54, 0, 0, 1'b1);
        wait_tiles(6, "t5_zero_tile");
        repeat (4) tick();
`ifdef PE_DISPATCH_ZERO_SKIP_EN
        check("t5_zero_starts", 64'(start_cnt), 64'd11);
`else
        check("t5_zero_starts", 64'(start_cnt), 64'd12);
        chk_lane("t5_z0", 11, 0, lane_val(53, 0, 5));
        chk_lane("t5_z1", 11, 1, lane_val(54, 0, 0));
        chk_lane("t5_zpad", 11, 2, {mk_addr(53), 32'd0});
`endif

        // 6: stray finish in FILL and in the ISSUE cycle
        auto_en = 1'b0;
        s0 = start_cnt;
        t0 = tile_cnt;
        fin_man = 1'b1;
        tick();
        tick();
        fin_man = 1'b0;
        tick();
        check("t6_fill_starts", 64'(start_cnt), 64'(s0));
        check("t6_fill_tiles", 64'(tile_cnt), 64'(t0));
        for (int i = 60; i <= 62; i++) push(i, 100 + i, 200 + i, 1'b0);
        for (int i = 0; i < 20 && !bus_if.o_start; i++) tick();
        check("t6_issue_seen", 64'(bus_if.o_start), 64'd1);
        fin_man = 1'b1;
        tick();
        fin_man = 1'b0;
        for (int i = 63; i <= 65; i++) push(i, 100 + i, 200 + i, 1'(i == 65));
        repeat (10) tick();
        check("t6_no_early_issue", 64'(start_cnt), 64'(s0 + 1));
        check("t6_issue_tiles", 64'(tile_cnt), 64'(t0));
        fin_man = 1'b1;
        tick();
        fin_man = 1'b0;
        auto_en = 1'b1;
        wait_tiles(t0 + 1, "t6_tile");
        repeat (3) tick();
        check("t6_starts", 64'(start_cnt), 64'(s0 + 2));
        for (int l = 0; l < 3; l++) chk_lane("t6_g0", s0, l, lane_val(60 + l, 160 + l, 260 + l));
        for (int l = 0; l < 3; l++) chk_lane("t6_g1", s0 + 1, l, lane_val(63 + l, 163 + l, 263 + l));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
